instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 mem_req/mem_addr  out  1/24  byte-read request and address.
REQ-004 mem_ack/mem_data  in  1/8  read complete; data valid in the same cycle as mem_ack; ack counts only while mem_req=1.
REQ-005 pc_load/pc_load_value  in  1/24  redirect (branch, interrupt) to a new fetch address.
REQ-006 dec_opcode/dec_opext  out  8/8  captured opcode and extension bytes, fed to the instruction decoder.
REQ-007 dec_need_opext, dec_need_imm, dec_imm_size, dec_error  in  1 each  decoder results for dec_opcode/dec_opext.
REQ-008 instr_valid/instr_ready  out/in  1/1  assembled-instruction handshake.
REQ-009 instr_opcode, instr_opext, instr_imm, instr_pc, instr_len  out  8,8,16,24,3  assembled instruction; instr_pc = address of the opcode byte; instr_len = byte count (1-4).
REQ-010 instr_illegal  out  1  instruction flagged illegal by the decoder.

Function
REQ-011 States: IDLE, OP, DEC1, EXT, DEC2, IMM_LO, IMM_HI, VALID.
REQ-012 mem_req SHALL be 1 exactly in OP, EXT, IMM_LO and IMM_HI; mem_addr SHALL equal the fetch PC, which increments by 1 on each accepted byte and wraps 0xFFFFFF->0x000000.
REQ-013 OP: on ack, capture the byte into dec_opcode, clear dec_opext to 0x00, record instr_pc, set len=1, go to DEC1.
REQ-014 DEC1 (one cycle): if dec_need_opext=1 go to EXT; else if dec_error=1 go to VALID with illegal=1; else if dec_need_imm=1 go to IMM_LO; else go to VALID.
REQ-015 EXT: on ack, capture dec_opext, len=2, go to DEC2. DEC2 applies the DEC1 rules except the dec_need_opext check.
REQ-016 IMM_LO: on ack, imm[7:0]=byte, imm[15:8]=0, len+=1; go to IMM_HI if dec_imm_size=1, else go to VALID. IMM_HI: on ack, imm[15:8]=byte, len+=1, go to VALID.
REQ-017 VALID: instr_valid=1 with all instr_* outputs stable; on instr_ready=1 go to OP in the next cycle; outputs hold while instr_ready=0.
REQ-018 pc_load=1 in any state SHALL, in the next cycle, set fetch PC=pc_load_value, clear instr_valid and instr_illegal, discard any partial instruction and mem_ack from that cycle, and enter OP; pc_load takes priority over a same-cycle ack or instr_ready.
REQ-019 Minimum latency, zero-wait memory: 1-byte instruction valid 3 cycles after OP entry; each extra byte adds 2 cycles (one fetch, one decode for the extension byte) or 1 cycle (immediate byte).

Reset
REQ-020 reset SHALL force the state to IDLE, fetch PC=0x000000, mem_req=0, instr_valid=0, instr_illegal=0, dec_opcode=dec_opext=0x00, instr_imm=0, instr_len=0.
REQ-021 IDLE SHALL go to OP on the first cycle after reset deasserts. Reset mid-fetch SHALL drop the request with no output.

Configuration
REQ-022 Macro INSTR_FETCH_ILLEGAL_HALT_EN.
REQ-023 When defined: after an illegal instruction is presented and accepted, the block SHALL stay in IDLE (mem_req=0) until pc_load.
REQ-024 When undefined: fetch continues at the next byte after an accepted illegal instruction; instr_illegal is still reported.

Verification
REQ-025 Memory 0x000000: 00 -> instr_valid with opcode 0x00, len 1, pc 0x000000, imm 0x0000.
REQ-026 Bytes C0 34 12 -> opcode 0xC0, imm 0x1234, len 3; next mem_addr 0x000003.
REQ-027 Bytes CE D0 78 56 -> opcode 0xCE, opext 0xD0, imm 0x5678, len 4.
REQ-028 Byte 7C (illegal) -> instr_illegal=1, len 1; with macro defined, mem_req stays 0 until pc_load.
REQ-029 pc_load=1, value 0x001000, asserted during IMM_LO with a same-cycle ack -> no instr_valid; next mem_addr 0x001000.
REQ-030 instr_ready held at 0 for 5 cycles in VALID -> outputs stable and mem_req=0; fetch resumes the cycle after ready.

Source files
------------

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads opcode, optional extension and immediate bytes, consulting an external decoder.
// Build macro INSTR_FETCH_ILLEGAL_HALT_EN: park in IDLE after an accepted illegal instruction until pc_load.
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        pc_load,
  input  logic [23:0] pc_load_value,
  output logic [7:0]  dec_opcode,
  output logic [7:0]  dec_opext,
  input  logic        dec_need_opext,
  input  logic        dec_need_imm,
  input  logic        dec_imm_size,
  input  logic        dec_error,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_opext,
  output logic [15:0] instr_imm,
  output logic [23:0] instr_pc,
  output logic [2:0]  instr_len,
  output logic        instr_illegal
);

`ifdef INSTR_FETCH_ILLEGAL_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, OP, DEC1, EXT, DEC2, IMM_LO, IMM_HI, VALID
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [23:0] fetch_pc;
  logic        halted;
  logic        byte_taken;

  function automatic state_t after_decode(input logic chk_ext, input logic need_ext,
                                          input logic err, input logic need_imm);
    if (chk_ext && need_ext) return EXT;
    if (err)                 return VALID;
    if (need_imm)            return IMM_LO;
    return VALID;
  endfunction

  function automatic logic is_fetch(input state_t s);
    return (s == OP) || (s == EXT) || (s == IMM_LO) || (s == IMM_HI);
  endfunction

  // mem_req is a registered decode of state, so an ack only counts in fetch states
  assign byte_taken   = mem_req && mem_ack;
  assign mem_addr     = fetch_pc;
  assign instr_opcode = dec_opcode;
  assign instr_opext  = dec_opext;

  always_comb begin
    state_n = state;
    if (pc_load) begin
      state_n = OP;
    end else begin
      case (state)
        IDLE:    if (!halted) state_n = OP;
        OP:      if (byte_taken) state_n = DEC1;
        DEC1:    state_n = after_decode(1'b1, dec_need_opext, dec_error, dec_need_imm);
        EXT:     if (byte_taken) state_n = DEC2;
        DEC2:    state_n = after_decode(1'b0, dec_need_opext, dec_error, dec_need_imm);
        IMM_LO:  if (byte_taken) state_n = dec_imm_size ? IMM_HI : VALID;
        IMM_HI:  if (byte_taken) state_n = VALID;
        VALID:   if (instr_ready) state_n = (HALT_EN && instr_illegal) ? IDLE : OP;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      fetch_pc      <= 24'h000000;
      mem_req       <= 1'b0;
      instr_valid   <= 1'b0;
      instr_illegal <= 1'b0;
      dec_opcode    <= 8'h00;
      dec_opext     <= 8'h00;
      instr_imm     <= 16'h0000;
      instr_len     <= 3'd0;
      instr_pc      <= 24'h000000;
      halted        <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req     <= is_fetch(state_n);
      instr_valid <= (state_n == VALID);
      // A redirect discards the in-flight instruction and any same-cycle ack
      if (pc_load) begin
        fetch_pc      <= pc_load_value;
        instr_illegal <= 1'b0;
        halted        <= 1'b0;
      end else begin
        case (state)
          OP: if (byte_taken) begin
            dec_opcode <= mem_data;
            dec_opext  <= 8'h00;
            instr_imm  <= 16'h0000;
            instr_pc   <= fetch_pc;
            instr_len  <= 3'd1;
            fetch_pc   <= fetch_pc + 24'd1;
          end
          DEC1: instr_illegal <= !dec_need_opext && dec_error;
          EXT: if (byte_taken) begin
            dec_opext <= mem_data;
            instr_len <= 3'd2;
            fetch_pc  <= fetch_pc + 24'd1;
          end
          DEC2: instr_illegal <= dec_error;
          IMM_LO: if (byte_taken) begin
            instr_imm <= {8'h00, mem_data};
            instr_len <= instr_len + 3'd1;
            fetch_pc  <= fetch_pc + 24'd1;
          end
          IMM_HI: if (byte_taken) begin
            instr_imm[15:8] <= mem_data;
            instr_len       <= instr_len + 3'd1;
            fetch_pc        <= fetch_pc + 24'd1;
          end
          VALID: if (instr_ready) begin
            instr_illegal <= 1'b0;
            if (HALT_EN && instr_illegal) halted <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: byte-stream reference model, memory and decoder responders.
module tb_instr_fetch;
  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        pc_load;
  logic [23:0] pc_load_value;
  logic [7:0]  dec_opcode;
  logic [7:0]  dec_opext;
  logic        dec_need_opext;
  logic        dec_need_imm;
  logic        dec_imm_size;
  logic        dec_error;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_opext;
  logic [15:0] instr_imm;
  logic [23:0] instr_pc;
  logic [2:0]  instr_len;
  logic        instr_illegal;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  ext;
    logic [15:0] imm;
    logic [23:0] pc;
    logic [2:0]  len;
    logic        ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [logic [23:0]];
  int         checks = 0;
  int         failures = 0;
  bit         ack_zero = 1'b1;
  bit         ready_rand = 1'b0;
  logic       ready_val = 1'b0;

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .dec_opcode(dec_opcode), .dec_opext(dec_opext),
    .dec_need_opext(dec_need_opext), .dec_need_imm(dec_need_imm),
    .dec_imm_size(dec_imm_size), .dec_error(dec_error),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_opext(instr_opext), .instr_imm(instr_imm),
    .instr_pc(instr_pc), .instr_len(instr_len), .instr_illegal(instr_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction set rules: returns {need_ext, error, need_imm, imm16}
  function automatic logic [3:0] rule(input logic [7:0] op, input logic [7:0] ext);
    if (op inside {[8'h70:8'h7F]}) return 4'b0100;
    if (op inside {[8'h80:8'hBF]}) return 4'b0010;
    if (op inside {[8'hC0:8'hCD]}) return 4'b0011;
    if (op inside {8'hCE, 8'hCF}) begin
      case (ext[7:6])
        2'b00:   return 4'b1000;
        2'b01:   return 4'b1100;
        2'b10:   return 4'b1010;
        default: return 4'b1011;
      endcase
    end
    return 4'b0000;
  endfunction

  assign {dec_need_opext, dec_error, dec_need_imm, dec_imm_size} = rule(dec_opcode, dec_opext);

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int detail);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=0", name, detail);
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [7:0] ext, input logic [15:0] imm,
                          input logic [23:0] pc, input logic [2:0] len, input logic ill);
    exp_t e;
    e.op = op; e.ext = ext; e.imm = imm; e.pc = pc; e.len = len; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Redirect to start, write n random instructions there, and queue what must come out
  task automatic issue_seg(input logic [23:0] start, input int n);
    logic [23:0] a;
    logic [7:0]  op, ext, lo, hi;
    logic [3:0]  r;
    int          nimm;
    int          kind;
    exp_t        e;
    pc_load = 1'b1;
    pc_load_value = start;
    exp_q.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 4);
      ext = 8'h00;
      case (kind)
        1: op = 8'($urandom_range(8'h80, 8'hBF));
        2: op = 8'($urandom_range(8'hC0, 8'hCD));
        3: begin
          op = 8'hCE | 8'($urandom_range(0, 1));
          ext = 8'($urandom);
          if (ext[7:6] == 2'b01) ext[7:6] = 2'b00;
        end
        4: begin
          if (i == n - 1) begin
            if ($urandom_range(0, 1) != 0) op = 8'h70 | 8'($urandom_range(0, 15));
            else begin op = 8'hCE; ext = 8'h40 | 8'($urandom_range(0, 63)); end
          end else op = 8'h00;
        end
        default: op = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8'h6F))
                                                  : 8'($urandom_range(8'hD0, 8'hFF));
      endcase
      r = rule(op, ext);
      lo = 8'($urandom);
      hi = 8'($urandom);
      nimm = r[1] ? (r[0] ? 2 : 1) : 0;
      e.op = op;
      e.ext = r[3] ? ext : 8'h00;
      e.pc = a;
      e.ill = r[2];
      e.imm = (nimm == 2) ? {hi, lo} : (nimm == 1) ? {8'h00, lo} : 16'h0000;
      e.len = 3'(1 + int'(r[3]) + nimm);
      mem[a] = op; a = a + 24'd1;
      if (r[3]) begin mem[a] = ext; a = a + 24'd1; end
      if (nimm > 0) begin mem[a] = lo; a = a + 24'd1; end
      if (nimm > 1) begin mem[a] = hi; a = a + 24'd1; end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_empty(input int budget, input bit must);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    if (must && exp_q.size() != 0) begin
      fail_now("drain_timeout", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory and ready responder, updated just after the falling edge
  initial begin
    mem_ack = 1'b0;
    mem_data = 8'h00;
    instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && (ack_zero || $urandom_range(0, 3) != 0)) begin
        mem_ack = 1'b1;
        mem_data = mem_rd(mem_addr);
      end else begin
        mem_ack = 1'b0;
        mem_data = 8'($urandom);
      end
      instr_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_val;
    end
  end

  // Monitor: every presented instruction is compared with the queue head, popped on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !pc_load && instr_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid", int'(instr_pc));
        end else begin
          e = exp_q[0];
          check("instr", 64'({instr_opcode, instr_opext, instr_imm, instr_pc, instr_len, instr_illegal}),
                64'(e));
          check("valid_next_addr", 64'({mem_req, mem_addr}), 64'({1'b0, e.pc + 24'(e.len)}));
          if (instr_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit found;
    logic [23:0] start;
    reset = 1'b1;
    pc_load = 1'b0;
    pc_load_value = 24'h000000;

    mem[24'h000000] = 8'h00;
    mem[24'h000001] = 8'hC0; mem[24'h000002] = 8'h34; mem[24'h000003] = 8'h12;
    mem[24'h000004] = 8'hCE; mem[24'h000005] = 8'hD0; mem[24'h000006] = 8'h78; mem[24'h000007] = 8'h56;
    mem[24'h000008] = 8'h7C;
    push_exp(8'h00, 8'h00, 16'h0000, 24'h000000, 3'd1, 1'b0);
    push_exp(8'hC0, 8'h00, 16'h1234, 24'h000001, 3'd3, 1'b0);
    push_exp(8'hCE, 8'hD0, 16'h5678, 24'h000004, 3'd4, 1'b0);
    push_exp(8'h7C, 8'h00, 16'h0000, 24'h000008, 3'd1, 1'b1);

    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_illegal", 64'(instr_illegal), 64'd0);
    check("rst_opcode", 64'(dec_opcode), 64'd0);
    check("rst_opext", 64'(dec_opext), 64'd0);
    check("rst_imm", 64'(instr_imm), 64'd0);
    check("rst_len", 64'(instr_len), 64'd0);
    reset = 1'b0;

    @(negedge clk);
    check("idle_to_op", 64'({mem_req, mem_addr}), 64'({1'b1, 24'h000000}));
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    if (!found) fail_now("first_valid_timeout", 20);
    for (int k = 0; k < 5; k++) begin
      check("hold_mem_req", 64'(mem_req), 64'd0);
      check("hold_valid", 64'(instr_valid), 64'd1);
      @(negedge clk);
    end
    ready_val = 1'b1;
    @(negedge clk);
    ready_val = 1'b0;
    check("resume_fetch", 64'({instr_valid, mem_req, mem_addr}), 64'({1'b0, 1'b1, 24'h000001}));
    ack_zero = 1'b0;
    ready_rand = 1'b1;
    wait_empty(400, 1'b1);

`ifdef INSTR_FETCH_ILLEGAL_HALT_EN
    for (int k = 0; k < 4; k++) begin
      check("halt_mem_req", 64'(mem_req), 64'd0);
      @(negedge clk);
    end
`else
    check("after_illegal_fetch", 64'({mem_req, mem_addr}), 64'({1'b1, 24'h000009}));
`endif

    // Redirect during IMM_LO with a same-cycle ack
    ack_zero = 1'b1;
    ready_rand = 1'b0;
    ready_val = 1'b0;
    mem[24'h000200] = 8'hC0; mem[24'h000201] = 8'hAA; mem[24'h000202] = 8'hBB;
    exp_q.delete();
    pc_load = 1'b1;
    pc_load_value = 24'h000200;
    @(negedge clk);
    pc_load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req && mem_addr == 24'h000201) begin found = 1'b1; break; end
      @(negedge clk);
    end
    if (!found) fail_now("imm_lo_timeout", 10);
    issue_seg(24'h001000, 4);
    @(negedge clk);
    pc_load = 1'b0;
    check("redirect_addr", 64'({instr_valid, mem_req, mem_addr}), 64'({1'b0, 1'b1, 24'h001000}));
    ack_zero = 1'b0;
    ready_rand = 1'b1;
    wait_empty(400, 1'b1);

    for (int s = 0; s < 30; s++) begin
      if (s == 0) start = 24'hFFFFFE;
      else if ($urandom_range(0, 4) == 0) start = 24'hFFFFFF - 24'($urandom_range(0, 5));
      else start = 24'($urandom);
      ack_zero = ($urandom_range(0, 2) == 0);
      issue_seg(start, $urandom_range(1, 6));
      @(negedge clk);
      pc_load = 1'b0;
      if ($urandom_range(0, 3) == 0) wait_empty($urandom_range(1, 20), 1'b0);
      else wait_empty(600, 1'b1);
    end
    wait_empty(600, 1'b1);

    // Reset in the middle of fetching drops the request
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_state", 64'({instr_valid, instr_illegal, instr_len, dec_opcode, mem_addr}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
